// File: rtl/mi_pkg.sv
// Shared definitions for the mi_* burst memory interface: field widths,
// read/write encoding and the responder FSM state encoding.
package mi_pkg;

    localparam int MI_LEN_W = 7;

    localparam logic MI_RW_READ  = 1'b1;
    localparam logic MI_RW_WRITE = 1'b0;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LAT  = 3'd1;
    localparam logic [2:0] ST_WR   = 3'd2;
    localparam logic [2:0] ST_RD   = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/mi_resp_ram.sv
// Simple dual-port synchronous word RAM: one write port, one read port with a
// registered output that only updates on a read and otherwise holds its value.
module mi_resp_ram #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Write port; contents are deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; the output register doubles as the interface
    // read-data register, so it clears on reset and holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mi_bram_responder.sv
// Responder end of the mi_* burst interface backed by on-chip RAM. Mimics the
// command/ack/strobe timing of the PSRAM controller with a fixed access
// latency between command acceptance and the first data beat.
module mi_bram_responder
    import mi_pkg::*;
#(
    parameter int AW      = 8,
    parameter int LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         mi_addr,
    input  logic [MI_LEN_W-1:0] mi_len,
    input  logic                mi_rw,
    input  logic                mi_valid,
    output logic                mi_ready,
    input  logic [31:0]         mi_wdata,
    output logic                mi_wack,
    output logic                mi_wlast,
    output logic [31:0]         mi_rdata,
    output logic                mi_rstb,
    output logic                mi_rlast
);

    // Latency counter preload; counts LATENCY cycles down to zero in LAT.
    localparam int LAT_LOAD = (LATENCY > 0) ? LATENCY - 1 : 0;

    logic [2:0]          state_reg;
    logic [AW-1:0]       addr_reg;
    logic [MI_LEN_W-1:0] cnt_reg;
    logic [3:0]          lat_reg;
    logic                rw_reg;
    logic                ready_reg;
    logic                wack_reg;
    logic                wlast_reg;
    logic                rstb_reg;
    logic                rlast_reg;

    // Only the low AW address bits select a word; the rest are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mi_addr[31:AW];

    // Command FSM, burst address/count and the registered strobes. Address
    // arithmetic wraps naturally at 2^AW. Read strobes are issued alongside
    // the RAM read so they line up with the registered RAM output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            cnt_reg   <= '0;
            lat_reg   <= '0;
            rw_reg    <= MI_RW_WRITE;
            ready_reg <= 1'b0;
            wack_reg  <= 1'b0;
            wlast_reg <= 1'b0;
            rstb_reg  <= 1'b0;
            rlast_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (mi_valid && ready_reg) begin
                        addr_reg  <= mi_addr[AW-1:0];
                        cnt_reg   <= mi_len;
                        rw_reg    <= mi_rw;
                        lat_reg   <= 4'(LAT_LOAD);
                        ready_reg <= 1'b0;
                        if (LATENCY > 0) begin
                            state_reg <= ST_LAT;
                        end else if (mi_rw == MI_RW_READ) begin
                            state_reg <= ST_RD;
                        end else begin
                            state_reg <= ST_WR;
                            wack_reg  <= 1'b1;
                            wlast_reg <= (mi_len == '0);
                        end
                    end else begin
                        ready_reg <= 1'b1;
                    end
                end
                ST_LAT: begin
                    if (lat_reg == '0) begin
                        if (rw_reg == MI_RW_WRITE) begin
                            state_reg <= ST_WR;
                            wack_reg  <= 1'b1;
                            wlast_reg <= (cnt_reg == '0);
                        end else begin
                            state_reg <= ST_RD;
                        end
                    end else begin
                        lat_reg <= lat_reg - 1'b1;
                    end
                end
                ST_WR: begin
                    // The RAM write of this beat happens on this same edge.
                    addr_reg <= addr_reg + 1'b1;
                    cnt_reg  <= cnt_reg - 1'b1;
                    if (cnt_reg == '0) begin
                        state_reg <= ST_DONE;
                        wack_reg  <= 1'b0;
                        wlast_reg <= 1'b0;
                    end else begin
                        wlast_reg <= (cnt_reg == MI_LEN_W'(1));
                    end
                end
                ST_RD: begin
                    addr_reg  <= addr_reg + 1'b1;
                    cnt_reg   <= cnt_reg - 1'b1;
                    rstb_reg  <= 1'b1;
                    rlast_reg <= (cnt_reg == '0);
                    if (cnt_reg == '0) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Stay until the last read strobe has drained, then reopen.
                    rstb_reg  <= 1'b0;
                    rlast_reg <= 1'b0;
                    if (!rstb_reg) begin
                        state_reg <= ST_IDLE;
                        ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    mi_resp_ram #(
        .AW (AW),
        .DW (32)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wack_reg),
        .waddr (addr_reg),
        .wdata (mi_wdata),
        .re    (state_reg == ST_RD),
        .raddr (addr_reg),
        .rdata (mi_rdata)
    );

    assign mi_ready = ready_reg;
    assign mi_wack  = wack_reg;
    assign mi_wlast = wlast_reg;
    assign mi_rstb  = rstb_reg;
    assign mi_rlast = rlast_reg;

endmodule

// File: tb/tb_mi_bram_responder.sv
// Bench for mi_bram_responder: one LATENCY=2 instance and one LATENCY=0
// instance share the command bus; sel steers mi_valid and the observed outputs.
module tb_mi_bram_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mi_addr = '0;
    logic [6:0]  mi_len = '0;
    logic        mi_rw = 1'b0;
    logic        mi_valid = 1'b0;
    logic [31:0] mi_wdata = '0;
    bit          sel = 1'b0;

    logic        rdy_a, wack_a, wlast_a, rstb_a, rlast_a;
    logic        rdy_b, wack_b, wlast_b, rstb_b, rlast_b;
    logic [31:0] rdata_a, rdata_b;

    logic        o_ready, o_wack, o_wlast, o_rstb, o_rlast;
    logic [31:0] o_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] model [2][256];
    logic [31:0] wbuf [128];

    always #5 clk = ~clk;

    mi_bram_responder #(.AW(8), .LATENCY(2)) dut_a (
        .clk(clk), .rst(rst), .mi_addr(mi_addr), .mi_len(mi_len), .mi_rw(mi_rw),
        .mi_valid(mi_valid & ~sel), .mi_ready(rdy_a), .mi_wdata(mi_wdata),
        .mi_wack(wack_a), .mi_wlast(wlast_a), .mi_rdata(rdata_a),
        .mi_rstb(rstb_a), .mi_rlast(rlast_a)
    );

    mi_bram_responder #(.AW(8), .LATENCY(0)) dut_b (
        .clk(clk), .rst(rst), .mi_addr(mi_addr), .mi_len(mi_len), .mi_rw(mi_rw),
        .mi_valid(mi_valid & sel), .mi_ready(rdy_b), .mi_wdata(mi_wdata),
        .mi_wack(wack_b), .mi_wlast(wlast_b), .mi_rdata(rdata_b),
        .mi_rstb(rstb_b), .mi_rlast(rlast_b)
    );

    assign o_ready = sel ? rdy_b   : rdy_a;
    assign o_wack  = sel ? wack_b  : wack_a;
    assign o_wlast = sel ? wlast_b : wlast_a;
    assign o_rstb  = sel ? rstb_b  : rstb_a;
    assign o_rlast = sel ? rlast_b : rlast_a;
    assign o_rdata = sel ? rdata_b : rdata_a;

    typedef struct {
        bit          s;
        logic [31:0] addr;
        int          len;
        bit          rw;
        logic [31:0] base;
        int          first;
        int          rdy;
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!o_ready && t < 300) begin
            step();
            t++;
        end
        chk("idle_ready", o_ready, 1);
    endtask

    // One burst on the selected instance; wbuf supplies write data. Timing
    // counts cycles from the acceptance cycle (cycle 0).
    task automatic run_burst(input bit s, input logic [31:0] addr, input int len,
                             input bit rw, input int exp_first, input int exp_rdy);
        int cyc, beats, first, rdy_cyc, stray;
        logic [7:0] a;
        sel = s;
        wait_ready();
        mi_addr = addr; mi_len = 7'(len); mi_rw = rw; mi_valid = 1'b1;
        step();
        mi_valid = 1'b0;
        mi_addr = $urandom;
        a = addr[7:0];
        cyc = 1; beats = 0; first = -1; rdy_cyc = -1; stray = 0;
        while (cyc < 400) begin
            if (o_ready) begin
                rdy_cyc = cyc;
                break;
            end
            if (rw ? o_rstb : o_wack) begin
                if (first < 0) first = cyc;
                chk("beat_contiguous", cyc, first + beats);
                chk("last_flag", rw ? o_rlast : o_wlast, beats == len);
                if (rw) begin
                    chk("rdata", o_rdata, model[s][8'(int'(a) + beats)]);
                end else begin
                    mi_wdata = wbuf[beats];
                    model[s][8'(int'(a) + beats)] = wbuf[beats];
                end
                beats++;
            end
            if (rw ? (o_wack | o_wlast) : (o_rstb | o_rlast)) stray++;
            step();
            cyc++;
        end
        chk("ready_cycle", rdy_cyc, exp_rdy);
        chk("first_beat", first, exp_first);
        chk("beat_count", beats, len + 1);
        chk("stray_strobes", stray, 0);
        $display("burst inst=%0d rw=%0d addr=0x%0h len=%0d beats=%0d first=%0d ready=%0d",
                 s, rw, addr, len, beats, first, rdy_cyc);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats, t, n, cyc, rdy;
        // Reset state
        repeat (3) step();
        chk("rst_ready_a", rdy_a, 0);
        chk("rst_wack_a", wack_a, 0);
        chk("rst_wlast_a", wlast_a, 0);
        chk("rst_rstb_a", rstb_a, 0);
        chk("rst_rlast_a", rlast_a, 0);
        chk("rst_rdata_a", rdata_a, 0);
        chk("rst_ready_b", rdy_b, 0);
        rst = 1'b0;
        step();
        chk("release_ready_a", rdy_a, 1);
        chk("release_ready_b", rdy_b, 1);

        // Fill both memories so every later read has a known expectation.
        for (int s = 0; s < 2; s++) begin
            for (int h = 0; h < 2; h++) begin
                for (int i = 0; i < 128; i++) wbuf[i] = $urandom;
                run_burst(s[0], 32'(h * 128), 127, 1'b0, (s == 0 ? 2 : 0) + 1,
                          1 + (s == 0 ? 2 : 0) + 128 + 1);
            end
        end

        // Directed table
        vecs[0] = '{1'b0, 32'h0000_0010, 0, 1'b0, 32'hDEAD_BEEF, 3, 5};
        vecs[1] = '{1'b0, 32'h0000_0010, 0, 1'b1, 32'h0,         4, 6};
        vecs[2] = '{1'b0, 32'h0000_0020, 7, 1'b0, 32'h0000_1000, 3, 12};
        vecs[3] = '{1'b0, 32'h0000_0020, 7, 1'b1, 32'h0,         4, 13};
        vecs[4] = '{1'b0, 32'hFFFF_00FE, 3, 1'b0, 32'h0000_00A0, 3, 8};
        vecs[5] = '{1'b0, 32'h0000_00FE, 3, 1'b1, 32'h0,         4, 9};
        vecs[6] = '{1'b1, 32'h0000_0005, 1, 1'b0, 32'h5555_0000, 1, 4};
        vecs[7] = '{1'b1, 32'h0000_0005, 1, 1'b1, 32'h0,         2, 5};
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < 128; i++) wbuf[i] = vecs[v].base + 32'(i);
            run_burst(vecs[v].s, vecs[v].addr, vecs[v].len, vecs[v].rw,
                      vecs[v].first, vecs[v].rdy);
        end
        chk("wrap_word_0", model[0][0], 32'h0000_00A2);
        chk("single_word", model[0][8'h10], 32'hDEAD_BEEF);

        // Busy: second command held valid during a 16-word read on LATENCY=2
        sel = 1'b0;
        wait_ready();
        mi_addr = 32'h40; mi_len = 7'd15; mi_rw = 1'b1; mi_valid = 1'b1;
        step();
        mi_addr = 32'h10; mi_len = 7'd0; mi_rw = 1'b1;
        cyc = 1; n = 0; rdy = -1;
        while (cyc < 60) begin
            if (o_ready) begin
                rdy = cyc;
                break;
            end
            if (o_rstb) n++;
            step();
            cyc++;
        end
        chk("busy_ready_cycle", rdy, 21);
        chk("busy_beats", n, 16);
        step();
        mi_valid = 1'b0;
        chk("busy_second_accepted", o_ready, 0);
        n = 0; t = 0;
        while (!o_ready && t < 20) begin
            if (o_rstb) begin
                n++;
                chk("busy_second_data", o_rdata, model[0][8'h10]);
                chk("busy_second_last", o_rlast, 1);
            end
            step();
            t++;
        end
        chk("busy_second_beats", n, 1);
        $display("busy test: first burst beats=16 ready at cycle %0d, second burst beats=%0d", rdy, n);

        // Reset during beat 3 of an 8-word read
        wait_ready();
        mi_addr = 32'h20; mi_len = 7'd7; mi_rw = 1'b1; mi_valid = 1'b1;
        step();
        mi_valid = 1'b0;
        beats = 0; t = 0;
        while (t < 50) begin
            if (o_rstb) beats++;
            if (beats == 3) break;
            step();
            t++;
        end
        chk("rst_mid_beats_seen", beats, 3);
        rst = 1'b1;
        #1;
        chk("rst_mid_rstb", o_rstb, 0);
        chk("rst_mid_rlast", o_rlast, 0);
        chk("rst_mid_ready", o_ready, 0);
        step();
        rst = 1'b0;
        step();
        chk("rst_mid_release_ready", o_ready, 1);
        chk("rst_mid_release_rstb", o_rstb, 0);
        $display("reset mid-burst: abandoned after %0d beats", beats);
        run_burst(1'b0, 32'h20, 7, 1'b1, 4, 13);

        // Randomized bursts against the memory model
        for (int r = 0; r < 40; r++) begin
            bit s, rw;
            int len, lat;
            s = 1'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            len = (r % 10 == 9) ? $urandom_range(0, 127) : $urandom_range(0, 20);
            lat = s ? 0 : 2;
            for (int i = 0; i < 128; i++) wbuf[i] = $urandom;
            run_burst(s, $urandom, len, rw, rw ? lat + 2 : lat + 1,
                      rw ? 1 + lat + (len + 1) + 2 : 1 + lat + (len + 1) + 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
